// File: rtl/hsi_axis_frame_source.sv
// AXI4-Stream frame source: emits NUM_PIXELS x NUM_BANDS beats of (seed + idx) in BIP order,
// with optional inter-beat gaps and a sticky watchdog for sinks that withhold TREADY too long.
module hsi_axis_frame_source #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned NUM_BANDS   = 8,
    parameter int unsigned NUM_PIXELS  = 4,
    parameter int unsigned GAP_W       = 4,
    parameter int unsigned STALL_LIMIT = 1024
) (
    input  logic                                      ap_clk,
    input  logic                                      ap_rst_n,
    input  logic                                      ap_start,
    output logic                                      ap_done,
    output logic                                      ap_idle,
    input  logic [DATA_W-1:0]                         seed,
    input  logic [GAP_W-1:0]                          gap_cycles,
    output logic [DATA_W-1:0]                         in_stream_TDATA,
    output logic                                      in_stream_TVALID,
    input  logic                                      in_stream_TREADY,
    output logic                                      in_stream_TLAST,
    output logic [$clog2(NUM_BANDS*NUM_PIXELS+1)-1:0] beat_count,
    output logic                                      stall_timeout
);

    localparam int unsigned N       = NUM_BANDS * NUM_PIXELS;
    localparam int unsigned IDX_W   = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CNT_W   = $clog2(N + 1);
    localparam int unsigned STALL_W = $clog2(STALL_LIMIT + 1);

    localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(N - 1);
    localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_LIMIT);
    localparam logic [GAP_W-1:0]   GAP_ONE   = GAP_W'(1);

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StGap,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [DATA_W-1:0]  seed_q, seed_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
    logic               timeout_q, timeout_d;

    logic valid;
    logic handshake;

    assign valid     = (state_q == StSend);
    assign handshake = valid & in_stream_TREADY;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        beat_cnt_d  = beat_cnt_q;
        seed_d      = seed_q;
        gap_d       = gap_q;
        gap_cnt_d   = gap_cnt_q;
        stall_cnt_d = stall_cnt_q;
        timeout_d   = timeout_q;

        unique case (state_q)
            StIdle: begin
                if (ap_start) begin
                    seed_d      = seed;
                    gap_d       = gap_cycles;
                    idx_d       = '0;
                    beat_cnt_d  = '0;
                    stall_cnt_d = '0;
                    timeout_d   = 1'b0;
                    state_d     = StSend;
                end
            end
            StSend: begin
                if (handshake) begin
                    beat_cnt_d  = beat_cnt_q + 1'b1;
                    idx_d       = idx_q + 1'b1;
                    stall_cnt_d = '0;
                    if (idx_q == LAST_IDX) begin
                        state_d = StDone;
                    end else if (gap_q != '0) begin
                        gap_cnt_d = gap_q;
                        state_d   = StGap;
                    end
                end else if (stall_cnt_q != STALL_MAX) begin
                    stall_cnt_d = stall_cnt_q + 1'b1;
                end
            end
            StGap: begin
                if (gap_cnt_q <= GAP_ONE) begin
                    state_d = StSend;
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Flag follows the counter reaching the limit; a handshake at the limit already saw it set.
        if (stall_cnt_d == STALL_MAX) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            beat_cnt_q  <= '0;
            seed_q      <= '0;
            gap_q       <= '0;
            gap_cnt_q   <= '0;
            stall_cnt_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            beat_cnt_q  <= beat_cnt_d;
            seed_q      <= seed_d;
            gap_q       <= gap_d;
            gap_cnt_q   <= gap_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    // Data derives from latched seed and idx only, so it is stable for as long as the beat waits.
    assign in_stream_TVALID = valid;
    assign in_stream_TDATA  = valid ? (seed_q + DATA_W'(idx_q)) : '0;
    assign in_stream_TLAST  = valid && (idx_q == LAST_IDX);
    assign ap_done          = (state_q == StDone);
    assign ap_idle          = (state_q == StIdle);
    assign beat_count       = beat_cnt_q;
    assign stall_timeout    = timeout_q;

endmodule

// File: tb/tb_hsi_axis_frame_source.sv
// Scoreboard bench for hsi_axis_frame_source: expected beats are queued at start and
// retired on each observed handshake.
`timescale 1ns/1ps
module tb_hsi_axis_frame_source;

    localparam int unsigned DATA_W      = 32;
    localparam int unsigned NUM_BANDS   = 8;
    localparam int unsigned NUM_PIXELS  = 4;
    localparam int unsigned GAP_W       = 4;
    localparam int unsigned STALL_LIMIT = 16;
    localparam int          N           = NUM_BANDS * NUM_PIXELS;
    localparam int          CNT_W       = $clog2(N + 1);

    logic              ap_clk     = 1'b0;
    logic              ap_rst_n   = 1'b0;
    logic              ap_start   = 1'b0;
    logic              ap_done;
    logic              ap_idle;
    logic [DATA_W-1:0] seed       = '0;
    logic [GAP_W-1:0]  gap_cycles = '0;
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready     = 1'b1;
    logic              tlast;
    logic [CNT_W-1:0]  beat_count;
    logic              stall_timeout;

    hsi_axis_frame_source #(
        .DATA_W      (DATA_W),
        .NUM_BANDS   (NUM_BANDS),
        .NUM_PIXELS  (NUM_PIXELS),
        .GAP_W       (GAP_W),
        .STALL_LIMIT (STALL_LIMIT)
    ) dut (
        .ap_clk           (ap_clk),
        .ap_rst_n         (ap_rst_n),
        .ap_start         (ap_start),
        .ap_done          (ap_done),
        .ap_idle          (ap_idle),
        .seed             (seed),
        .gap_cycles       (gap_cycles),
        .in_stream_TDATA  (tdata),
        .in_stream_TVALID (tvalid),
        .in_stream_TREADY (tready),
        .in_stream_TLAST  (tlast),
        .beat_count       (beat_count),
        .stall_timeout    (stall_timeout)
    );

    always #5 ap_clk = ~ap_clk;

    int cyc = 0;
    always @(posedge ap_clk) cyc <= cyc + 1;

    int n_pass  = 0;
    int n_total = 0;

    logic [32:0] sb[$];   // {tlast, tdata}

    bit rand_ready = 1'b0;
    bit spacing_en = 1'b0;
    int exp_gap    = 0;
    int start_cyc  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge ap_clk);
        #1;
        if (rand_ready) tready = 1'($urandom_range(0, 1));
    endtask

    task automatic push_frame(input logic [31:0] s);
        for (int i = 0; i < N; i++) begin
            logic [31:0] d;
            d = s + 32'(i);
            sb.push_back({(i == N - 1), d});
        end
    endtask

    task automatic start_frame(input logic [31:0] s, input int g, input bit hold);
        ap_start   = 1'b1;
        seed       = s;
        gap_cycles = GAP_W'(g);
        push_frame(s);
        step();
        if (!hold) ap_start = 1'b0;
        start_cyc = cyc;
        check_eq("first_valid", 64'(tvalid), 64'd1);
    endtask

    task automatic wait_done(input int limit);
        int n;
        n = 0;
        while (ap_done !== 1'b1 && n < limit) begin
            step();
            n++;
        end
        check_eq("done_seen", 64'(ap_done), 64'd1);
    endtask

    task automatic finish_frame(input int sb_left);
        wait_done(2000);
        check_eq("beat_count", 64'(beat_count), 64'(N));
        check_eq("sb_level", 64'(sb.size()), 64'(sb_left));
        step();
        check_eq("done_one_cycle", 64'(ap_done), 64'd0);
        check_eq("idle_after_done", 64'(ap_idle), 64'd1);
    endtask

    // Monitor: handshakes retire scoreboard entries; stalled beats must hold still.
    bit          prev_stall   = 1'b0;
    logic [31:0] held_data    = '0;
    logic        held_last    = 1'b0;
    bit          have_prev_hs = 1'b0;
    int          prev_hs_cyc  = 0;

    always @(negedge ap_clk) begin
        logic [32:0] e;
        if (!ap_rst_n) begin
            prev_stall   = 1'b0;
            have_prev_hs = 1'b0;
        end else begin
            if (prev_stall) begin
                check_eq("valid_hold", 64'(tvalid), 64'd1);
                check_eq("data_hold", 64'(tdata), 64'(held_data));
                check_eq("last_hold", 64'(tlast), 64'(held_last));
            end
            if (tvalid && tready) begin
                if (sb.size() == 0) begin
                    check_eq("sb_extra_beat", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check_eq("tdata", 64'(tdata), 64'(e[31:0]));
                    check_eq("tlast", 64'(tlast), 64'(e[32]));
                end
                if (spacing_en && have_prev_hs) begin
                    check_eq("beat_spacing", 64'(cyc - prev_hs_cyc), 64'(exp_gap + 1));
                end
                have_prev_hs = !tlast;
                prev_hs_cyc  = cyc;
                prev_stall   = 1'b0;
            end else if (tvalid) begin
                prev_stall = 1'b1;
                held_data  = tdata;
                held_last  = tlast;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        #23;
        check_eq("rst_done", 64'(ap_done), 64'd0);
        check_eq("rst_idle", 64'(ap_idle), 64'd1);
        check_eq("rst_tvalid", 64'(tvalid), 64'd0);
        check_eq("rst_tlast", 64'(tlast), 64'd0);
        check_eq("rst_tdata", 64'(tdata), 64'd0);
        check_eq("rst_beat_count", 64'(beat_count), 64'd0);
        check_eq("rst_stall_timeout", 64'(stall_timeout), 64'd0);
        ap_rst_n = 1'b1;
        step();

        // Back-to-back frame.
        tready = 1'b1; spacing_en = 1'b1; exp_gap = 0;
        start_frame(32'h100, 0, 1'b0);
        finish_frame(0);
        check_eq("len_gap0", 64'(cyc - 1 - start_cyc), 64'(N));

        // Gap of 3 between beats.
        exp_gap = 3;
        start_frame(32'h200, 3, 1'b0);
        wait_done(2000);
        check_eq("len_gap3", 64'(cyc - start_cyc), 64'((N - 1) * 4 + 1));
        check_eq("sb_gap3", 64'(sb.size()), 64'd0);
        step();

        // Random backpressure with wrapping data.
        spacing_en = 1'b0; rand_ready = 1'b1;
        start_frame(32'hFFFF_FFF0, 0, 1'b0);
        finish_frame(0);
        rand_ready = 1'b0; tready = 1'b1;

        // Watchdog.
        tready = 1'b0;
        start_frame(32'h400, 0, 1'b0);
        repeat (15) step();
        check_eq("wd_before_limit", 64'(stall_timeout), 64'd0);
        step();
        check_eq("wd_set", 64'(stall_timeout), 64'd1);
        repeat (4) step();
        tready = 1'b1;
        finish_frame(0);
        check_eq("wd_sticky", 64'(stall_timeout), 64'd1);
        start_frame(32'h500, 0, 1'b0);
        check_eq("wd_cleared", 64'(stall_timeout), 64'd0);
        finish_frame(0);

        // Asynchronous reset mid-frame.
        start_frame(32'h600, 0, 1'b0);
        repeat (10) step();
        check_eq("pre_rst_count", 64'(beat_count), 64'd10);
        ap_rst_n = 1'b0;
        #1;
        check_eq("mid_rst_tvalid", 64'(tvalid), 64'd0);
        check_eq("mid_rst_tlast", 64'(tlast), 64'd0);
        check_eq("mid_rst_count", 64'(beat_count), 64'd0);
        check_eq("mid_rst_idle", 64'(ap_idle), 64'd1);
        sb.delete();
        repeat (2) step();
        ap_rst_n = 1'b1;
        step();
        start_frame(32'h600, 0, 1'b0);
        finish_frame(0);
        check_eq("len_after_rst", 64'(cyc - 1 - start_cyc), 64'(N));

        // Start pulses during SEND and GAP are ignored, as are seed/gap changes.
        spacing_en = 1'b1; exp_gap = 2;
        start_frame(32'h700, 2, 1'b0);
        ap_start = 1'b1; seed = 32'h999; gap_cycles = '0;
        repeat (3) step();
        ap_start = 1'b0;
        wait_done(2000);
        check_eq("len_ignored_start", 64'(cyc - start_cyc), 64'((N - 1) * 3 + 1));
        check_eq("sb_ignored_start", 64'(sb.size()), 64'd0);
        step();
        check_eq("idle_ignored_start", 64'(ap_idle), 64'd1);
        step();
        check_eq("no_retrigger", 64'(tvalid), 64'd0);

        // ap_start held: DONE, IDLE, then the next frame.
        exp_gap = 0;
        start_frame(32'h800, 0, 1'b1);
        push_frame(32'h800);
        finish_frame(N);
        step();
        check_eq("retrigger_valid", 64'(tvalid), 64'd1);
        start_cyc = cyc;
        ap_start = 1'b0;
        finish_frame(0);
        check_eq("len_retrigger", 64'(cyc - 1 - start_cyc), 64'(N));

        check_eq("sb_final", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/hsi_axis_frame_source.md
# hsi_axis_frame_source

Synthesizable AXI4-Stream frame source driving the hyperspectral kernel's `in_stream` port in band-interleaved-by-pixel order. It produces a deterministic, seeded pixel×band pattern with programmable inter-beat gaps. A stall watchdog flags when the kernel withholds TREADY too long, so the source end of the stream self-reports deadlock without simulation-only monitors.

## Interface
- `DATA_W`, 32: width of TDATA.
- `NUM_BANDS`, 8: beats per pixel.
- `NUM_PIXELS`, 4: pixels per frame; frame length `N = NUM_BANDS*NUM_PIXELS`.
- `GAP_W`, 4: width of `gap_cycles`.
- `STALL_LIMIT`, 1024: consecutive stalled cycles that raise `stall_timeout`; must be ≥1.

- `ap_clk` in 1: single clock; all logic on rising edge.
- `ap_rst_n` in 1: asynchronous assert, active-low reset.
- `ap_start` in 1: start one frame; sampled only in IDLE.
- `ap_done` out 1: one-cycle pulse after the last beat is accepted.
- `ap_idle` out 1: high while in IDLE.
- `seed` in DATA_W: pattern base, latched on start.
- `gap_cycles` in GAP_W: idle cycles inserted after each accepted beat, latched on start.
- `in_stream_TDATA` out DATA_W: beat data.
- `in_stream_TVALID` out 1: beat valid.
- `in_stream_TREADY` in 1: sink ready.
- `in_stream_TLAST` out 1: high on beat N-1 only.
- `beat_count` out clog2(N+1): beats accepted in the current or last frame.
- `stall_timeout` out 1: sticky watchdog flag.

## Operation
- FSM states: IDLE, SEND, GAP, DONE.
- IDLE: `ap_idle`=1, TVALID=0. `ap_start`=1 latches `seed` and `gap_cycles`, clears `beat_count`, the beat index, the stall counter and `stall_timeout`, then moves to SEND.
- SEND: TVALID=1, `TDATA = seed + idx` (mod 2^DATA_W), where idx is the beat index 0..N-1. `TLAST = (idx == N-1)`.
- TDATA and TLAST stay stable while TVALID=1 and TREADY=0. TVALID never drops without a handshake.
- Handshake (TVALID & TREADY): `beat_count`++ and idx++. Next state:
  - DONE if idx was N-1;
  - else GAP with gap counter = latched gap, if latched gap ≠ 0;
  - else stay in SEND with the next beat, back-to-back.
- GAP: TVALID=0. The counter decrements each cycle; when it reaches 1, move to SEND.
- DONE: `ap_done`=1 for exactly one cycle, then return to IDLE. `beat_count` holds N until the next start.
- Watchdog: the stall counter increments on each cycle with TVALID=1 & TREADY=0 and saturates at STALL_LIMIT. It clears on any handshake. At STALL_LIMIT, `stall_timeout` sets and stays set until the next accepted start or reset.
- The frame is not aborted on timeout; the source keeps waiting.
- Pixel/band position: band = idx mod NUM_BANDS, pixel = idx / NUM_BANDS. Only idx is stored.

## Timing
- Reset values: `ap_done`=0, `ap_idle`=1, TVALID=0, TLAST=0, TDATA=0, `beat_count`=0, `stall_timeout`=0, state IDLE.
- Reset mid-frame forces the reset values immediately (asynchronous), truncating the frame. The frame does not resume.
- `ap_start` high at edge k in IDLE: TVALID=1 from cycle k+1.
- With TREADY=1 and gap=0: beats in cycles k+1..k+N, `ap_done` in cycle k+N+1, `ap_idle`=1 from cycle k+N+2.
- With gap=g: beats are spaced g+1 cycles apart. No gap follows the last beat.
- `ap_start` outside IDLE is ignored. `ap_start` held high re-triggers on the cycle after DONE, when IDLE is entered.
- Changes to `seed`/`gap_cycles` during a frame have no effect.
- `stall_timeout` rises on the cycle after the STALL_LIMIT-th consecutive stalled cycle. A handshake in that same cycle still sets the flag if the limit was already reached.

## Test plan
- Parameters N=32, seed=0x100, gap=0, TREADY=1: 32 beats with TDATA 0x100..0x11F on consecutive cycles; TLAST only on 0x11F; `ap_done` one cycle later; `beat_count`=32.
- gap=3, TREADY=1: valid beats 4 cycles apart; TVALID=0 for exactly 3 cycles between beats; total frame 1+31×4 beat cycles.
- TREADY toggled randomly, seed=0xFFFFFFF0: TDATA wraps to 0x0 at beat 16; data and TLAST stable under backpressure; no beat lost or duplicated.
- STALL_LIMIT=16, TREADY=0 for 20 cycles after the first valid: `stall_timeout`=1 from the cycle after the 16th stalled cycle. The flag stays 1 after TREADY returns and the frame completes. The next `ap_start` clears it.
- `ap_rst_n` pulsed low at beat 10: TVALID and TLAST drop to 0 asynchronously, `beat_count`=0, `ap_idle`=1. A new start sends a full frame from `seed`.
- `ap_start` pulsed during SEND and GAP: no effect. `ap_start` held high continuously: back-to-back frames separated by the DONE and IDLE cycles.
